// File: rtl/video_timing_pkg.sv
// video_timing_pkg: timing profile types, built-in mode table and per-mode limit helper
package video_timing_pkg;
  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
  } timing_t;
  typedef timing_t [0:3] table_t;
  typedef struct packed {
    logic [17:0] h_act;
    logic [17:0] h_ss;
    logic [17:0] h_se;
    logic [17:0] h_total;
    logic [17:0] v_act;
    logic [17:0] v_ss;
    logic [17:0] v_se;
    logic [17:0] v_total;
  } limits_t;
  typedef enum logic {RUN, PENDING} sw_state_t;
  localparam table_t MODE_TABLE = '{
    '{16'd1280, 16'd110, 16'd40,  16'd220, 16'd720,  16'd5, 16'd5, 16'd20},
    '{16'd640,  16'd16,  16'd96,  16'd48,  16'd480,  16'd10, 16'd2, 16'd33},
    '{16'd800,  16'd40,  16'd128, 16'd88,  16'd600,  16'd1, 16'd4, 16'd23},
    '{16'd1920, 16'd88,  16'd44,  16'd148, 16'd1080, 16'd4, 16'd5, 16'd36}
  };
  // Sync start (inclusive), sync end (exclusive) and totals, widened so sums cannot overflow.
  function automatic limits_t limits(timing_t t);
    limits_t l;
    l.h_act   = 18'(t.h_active);
    l.h_ss    = l.h_act + 18'(t.h_fp);
    l.h_se    = l.h_ss + 18'(t.h_sync);
    l.h_total = l.h_se + 18'(t.h_bp);
    l.v_act   = 18'(t.v_active);
    l.v_ss    = l.v_act + 18'(t.v_fp);
    l.v_se    = l.v_ss + 18'(t.v_sync);
    l.v_total = l.v_se + 18'(t.v_bp);
    return l;
  endfunction
endpackage

// File: rtl/video_timing_gen_multi.sv
// video_timing_gen_multi: multi-mode raster timing generator with frame-boundary mode switching
module video_timing_gen_multi
  import video_timing_pkg::*;
#(
  parameter int NUM_MODES = 2,
  parameter int H_WIDTH = 12,
  parameter int V_WIDTH = 11,
  parameter int FC_WIDTH = 6,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1,
  parameter table_t TABLE = MODE_TABLE,
  localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic                clk_pixel_in,
  input  logic                rst_in,
  input  logic                en_in,
  input  logic [MW-1:0]       mode_sel_in,
  input  logic                mode_req_in,
  output logic [H_WIDTH-1:0]  hcount_out,
  output logic [V_WIDTH-1:0]  vcount_out,
  output logic                hs_out,
  output logic                vs_out,
  output logic                ad_out,
  output logic                nl_out,
  output logic                nf_out,
  output logic [FC_WIDTH-1:0] fc_out,
  output logic [MW-1:0]       mode_out,
  output logic                mode_ack_out
);
  sw_state_t state, state_nx;
  logic [MW-1:0] mode, pend, pend_nx;
  logic [H_WIDTH-1:0] h;
  logic [V_WIDTH-1:0] v;
  logic [FC_WIDTH-1:0] fc;
  logic [17:0] hx, vx;
  limits_t lim;
  logic h_end, v_end, wrap, req_ok, apply, nl_c, nf_c;
  assign lim = limits(TABLE[2'(mode)]);
  assign hx = 18'(h);
  assign vx = 18'(v);
  assign h_end = hx == lim.h_total - 18'd1;
  assign v_end = vx == lim.v_total - 18'd1;
  assign wrap = en_in && h_end && v_end;
  assign req_ok = en_in && mode_req_in && ({1'b0, mode_sel_in} < (MW+1)'(NUM_MODES));
  assign nl_c = hx == lim.h_act - 18'd1;
  assign nf_c = nl_c && vx == lim.v_act;
  assign mode_out = mode;
  assign fc_out = fc;
  // Switch FSM state and latched request index
  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      state <= RUN;
      pend <= '0;
    end else begin
      state <= state_nx;
      pend <= pend_nx;
    end
  end
  // Next state: any valid request (re)arms PENDING, the frame wrap always returns to RUN
  always_comb begin
    state_nx = wrap ? RUN : (req_ok ? PENDING : state);
    pend_nx = req_ok ? mode_sel_in : pend;
  end
  // Switch output: apply at the wrap, including a request arriving on the wrap cycle itself
  always_comb begin
    apply = wrap && (req_ok || state == PENDING);
  end
  // Raster counters, mode register, frame count and registered decodes of the pre-increment counters
  always_ff @(posedge clk_pixel_in) begin
    assert (rst_in || (lim.h_total <= (18'd1 << H_WIDTH) && lim.v_total <= (18'd1 << V_WIDTH)));
    if (rst_in) begin
      h <= '0;
      v <= '0;
      mode <= '0;
      fc <= '0;
      hcount_out <= '0;
      vcount_out <= '0;
      hs_out <= !HS_POL;
      vs_out <= !VS_POL;
      ad_out <= 1'b0;
      nl_out <= 1'b0;
      nf_out <= 1'b0;
      mode_ack_out <= 1'b0;
    end else if (en_in) begin
      h <= h_end ? '0 : h + H_WIDTH'(1);
      v <= h_end ? (v_end ? '0 : v + V_WIDTH'(1)) : v;
      mode <= apply ? pend_nx : mode;
      fc <= fc + FC_WIDTH'(nf_c);
      hcount_out <= h;
      vcount_out <= v;
      hs_out <= (hx >= lim.h_ss && hx < lim.h_se) ? HS_POL : !HS_POL;
      vs_out <= (vx >= lim.v_ss && vx < lim.v_se) ? VS_POL : !VS_POL;
      ad_out <= hx < lim.h_act && vx < lim.v_act;
      nl_out <= nl_c;
      nf_out <= nf_c;
      mode_ack_out <= apply;
    end else begin
      nl_out <= 1'b0;
      nf_out <= 1'b0;
      mode_ack_out <= 1'b0;
    end
  end
endmodule

// File: tb/tb_video_timing_gen_multi.sv
// tb_video_timing_gen_multi: scoreboard bench using small raster profiles so whole frames stay short
module tb_video_timing_gen_multi;
  import video_timing_pkg::*;
  localparam bit HSP = 1'b0;
  localparam bit VSP = 1'b1;
  // mode 0: 16x9 raster, mode 1: 10x6, mode 2: 8x5
  localparam table_t TB_TABLE = '{
    '{16'd8, 16'd2, 16'd3, 16'd3, 16'd4, 16'd1, 16'd2, 16'd2},
    '{16'd6, 16'd1, 16'd2, 16'd1, 16'd3, 16'd1, 16'd1, 16'd1},
    '{16'd4, 16'd1, 16'd1, 16'd2, 16'd2, 16'd1, 16'd1, 16'd1},
    '{16'd8, 16'd2, 16'd3, 16'd3, 16'd4, 16'd1, 16'd2, 16'd2}
  };
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic req = 1'b0;
  logic [1:0] sel = '0;
  logic [11:0] hc;
  logic [10:0] vc;
  logic hs, vs, ad, nl, nf, ack;
  logic [5:0] fc;
  logic [1:0] mode;
  video_timing_gen_multi #(
    .NUM_MODES(3), .H_WIDTH(12), .V_WIDTH(11), .FC_WIDTH(6),
    .HS_POL(HSP), .VS_POL(VSP), .TABLE(TB_TABLE)
  ) dut (
    .clk_pixel_in(clk), .rst_in(rst), .en_in(en), .mode_sel_in(sel), .mode_req_in(req),
    .hcount_out(hc), .vcount_out(vc), .hs_out(hs), .vs_out(vs), .ad_out(ad),
    .nl_out(nl), .nf_out(nf), .fc_out(fc), .mode_out(mode), .mode_ack_out(ack)
  );
  always #5 clk = ~clk;
  typedef struct {int h; int v; int fc; int mode;} ev_t;
  ev_t nf_q[$];
  ev_t ack_q[$];
  int tests = 0;
  int fails = 0;
  int ad_n, hs_n, vs_n, nl_n, hs_lo, hs_hi, vs_lo, vs_hi, h_max, v_max;
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic push_nf(input int h, input int v, input int f, input int m);
    ev_t e;
    e = '{h, v, f, m};
    nf_q.push_back(e);
  endtask
  task automatic push_ack(input int h, input int v, input int m);
    ev_t e;
    e = '{h, v, 0, m};
    ack_q.push_back(e);
  endtask
  // Monitor: every strobe the DUT presents is matched against the next expected event
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (nf) begin
        if (nf_q.size() == 0) chk("nf_unexpected", 1, 0);
        else begin
          e = nf_q.pop_front();
          chk("nf_h", int'(hc), e.h);
          chk("nf_v", int'(vc), e.v);
          chk("nf_fc", int'(fc), e.fc);
          chk("nf_mode", int'(mode), e.mode);
        end
      end
      if (ack) begin
        if (ack_q.size() == 0) chk("ack_unexpected", 1, 0);
        else begin
          e = ack_q.pop_front();
          chk("ack_h", int'(hc), e.h);
          chk("ack_v", int'(vc), e.v);
          chk("ack_mode", int'(mode), e.mode);
        end
      end
    end
  end
  task automatic clr();
    ad_n = 0; hs_n = 0; vs_n = 0; nl_n = 0;
    hs_lo = 9999; hs_hi = -1; vs_lo = 9999; vs_hi = -1; h_max = -1; v_max = -1;
  endtask
  task automatic cyc();
    @(negedge clk);
    if (!rst) begin
      ad_n += int'(ad);
      nl_n += int'(nl);
      if (hs == HSP) begin
        hs_n++;
        hs_lo = (int'(hc) < hs_lo) ? int'(hc) : hs_lo;
        hs_hi = (int'(hc) > hs_hi) ? int'(hc) : hs_hi;
      end
      if (vs == VSP) begin
        vs_n++;
        vs_lo = (int'(vc) < vs_lo) ? int'(vc) : vs_lo;
        vs_hi = (int'(vc) > vs_hi) ? int'(vc) : vs_hi;
      end
      h_max = (int'(hc) > h_max) ? int'(hc) : h_max;
      v_max = (int'(vc) > v_max) ? int'(vc) : v_max;
    end
  endtask
  task automatic run(input int n, input int r0 = -1, input int s0 = 0, input int r1 = -1,
                     input int s1 = 0, input int r2 = -1, input int s2 = 0, input bit tog = 1'b0);
    for (int i = 0; i < n; i++) begin
      en = tog ? (i % 2 == 0) : 1'b1;
      req = (i == r0) || (i == r1) || (i == r2);
      sel = 2'((i == r0) ? s0 : (i == r1) ? s1 : s2);
      cyc();
    end
    req = 1'b0;
    en = 1'b1;
  endtask
  task automatic chk_stats(input string tag, input int e_ad, input int e_hs, input int e_vs, input int e_nl,
                           input int e_hlo, input int e_hhi, input int e_vlo, input int e_vhi,
                           input int e_hmax, input int e_vmax);
    chk({tag, "_ad"}, ad_n, e_ad);
    chk({tag, "_hs"}, hs_n, e_hs);
    chk({tag, "_vs"}, vs_n, e_vs);
    chk({tag, "_nl"}, nl_n, e_nl);
    chk({tag, "_hs_lo"}, hs_lo, e_hlo);
    chk({tag, "_hs_hi"}, hs_hi, e_hhi);
    chk({tag, "_vs_lo"}, vs_lo, e_vlo);
    chk({tag, "_vs_hi"}, vs_hi, e_vhi);
    chk({tag, "_hmax"}, h_max, e_hmax);
    chk({tag, "_vmax"}, v_max, e_vmax);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_h"}, int'(hc), 0);
    chk({tag, "_v"}, int'(vc), 0);
    chk({tag, "_hs"}, int'(hs), 1);
    chk({tag, "_vs"}, int'(vs), 0);
    chk({tag, "_ad"}, int'(ad), 0);
    chk({tag, "_nl"}, int'(nl), 0);
    chk({tag, "_nf"}, int'(nf), 0);
    chk({tag, "_fc"}, int'(fc), 0);
    chk({tag, "_mode"}, int'(mode), 0);
    chk({tag, "_ack"}, int'(ack), 0);
  endtask
  initial begin
    clr();
    repeat (3) cyc();
    chk_reset("rst");
    rst = 1'b0;
    push_nf(7, 4, 1, 0);
    clr();
    run(144);
    chk_stats("m0", 32, 27, 32, 9, 10, 12, 5, 6, 15, 8);
    for (int f = 2; f <= 64; f++) begin
      push_nf(7, 4, f % 64, 0);
      run(144);
    end
    chk("fc_wrap", int'(fc), 0);
    push_nf(7, 4, 1, 0);
    push_ack(15, 8, 1);
    run(144, 80, 1);
    chk("mode_after_sw1", int'(mode), 1);
    push_nf(5, 3, 2, 1);
    clr();
    run(60);
    chk_stats("m1", 18, 12, 10, 6, 7, 8, 4, 4, 9, 5);
    push_nf(5, 3, 3, 1);
    push_ack(9, 5, 0);
    run(60, 10, 2, 20, 0, 30, 3);
    chk("mode_after_double", int'(mode), 0);
    push_nf(7, 4, 4, 0);
    run(144, 10, 3);
    chk("mode_after_oor", int'(mode), 0);
    push_nf(7, 4, 5, 0);
    push_ack(15, 8, 2);
    run(144, 143, 2);
    chk("mode_after_coinc", int'(mode), 2);
    push_nf(3, 2, 6, 2);
    clr();
    run(80, -1, 0, -1, 0, -1, 0, 1'b1);
    chk_stats("m2_tog", 16, 10, 16, 5, 5, 5, 3, 3, 7, 4);
    run(15, 3, 1);
    rst = 1'b1;
    cyc();
    cyc();
    chk_reset("rst_pend");
    rst = 1'b0;
    push_nf(7, 4, 1, 0);
    run(144);
    chk("mode_after_rst", int'(mode), 0);
    run(4);
    chk("nf_q_left", nf_q.size(), 0);
    chk("ack_q_left", ack_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
